exc_sequencer: RTL and testbench
================================

Name: exc_sequencer

Overview:
- Sequences exception entry and ERET return around Coprocessor 0.
- Collects exception requests from the IF/ID/EX/MEM pipeline stages and picks the oldest one.
- Flushes the pipeline, writes C0_EPC, C0_CAUSE, C0_BadAR and C0_SR one at a time through the single CP0 write port, then redirects fetch.
- Sits between the pipeline hazard unit, the PC mux and the coprocessor.

Parameters:
- KERNEL_VEC, 32'h80000180, exception handler entry address.
- FLUSH_CYCLES, 2, number of cycles flush[] is held (1..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- exc_valid  in  4  per-stage request; bit0=IF, 1=ID, 2=EX, 3=MEM
- exc_code  in  20  5-bit ExcCode per stage; stage i uses [5i+4:5i]
- exc_pc  in  128  faulting PC per stage; stage i uses [32i+31:32i]
- exc_badaddr  in  32  faulting address, valid alongside MEM/IF address errors
- eret  in  1  ERET retiring in MEM
- sr_in  in  32  current C0_SR
- epc_in  in  32  current C0_EPC
- cop_we  out  1  CP0 write enable
- cop_wreg  out  5  CP0 write register index
- cop_wdata  out  32  CP0 write data
- flush  out  4  per-stage flush
- stall  out  1  freezes the pipeline
- pc_redirect  out  1  one-cycle PC override
- pc_target  out  32  redirect address

Behaviour:
- Reset:
  - State is IDLE.
  - All outputs are 0.
  - Latched code, pc and badaddr registers are 0.
  - Reset mid-sequence aborts immediately; no further CP0 writes are issued.
- stall = 1 in every state except IDLE.
- cop_we, pc_redirect and flush are 0 unless a state below drives them.
- IDLE:
  - If any exc_valid bit is set, select the highest set index (MEM oldest).
  - Latch its code, its pc and exc_badaddr.
  - Set sel_stage and skip_epc = sr_in[1] (EXL already set).
  - Go to FLUSH and load the counter with FLUSH_CYCLES.
  - Else if eret: go to ERET_SR.
  - If exceptions and eret occur together, the exception wins and eret is dropped.
- FLUSH:
  - flush[i] = 1 for every i <= sel_stage; the counter decrements.
  - When the counter reaches 1: go to W_EPC, or to W_CAUSE if skip_epc.
- W_EPC: cop_we=1, wreg=14, wdata=latched pc.
- W_CAUSE:
  - cop_we=1, wreg=13, wdata = {25'b0, code, 2'b0}.
  - If code is 4 (AdEL) or 5 (AdES), go to W_BADAR; otherwise go to W_SR.
- W_BADAR: cop_we=1, wreg=8, wdata=latched badaddr.
- W_SR: cop_we=1, wreg=12, wdata = sr_in with bit1 (EXL) set and bit4 (UM) cleared.
- REDIRECT:
  - pc_redirect=1, pc_target=KERNEL_VEC for one cycle.
  - flush = 4'b1111 in the same cycle.
  - Then go to IDLE.
- ERET_SR:
  - cop_we=1, wreg=12, wdata = sr_in with EXL cleared and UM set.
  - Go to ERET_RD.
- ERET_RD:
  - pc_redirect=1, pc_target=epc_in, flush=4'b1111.
  - Then go to IDLE.
- Any exc_valid or eret seen in a non-IDLE state is ignored; the pipeline is stalled, and flushed requests do not recur.
- Latency, exception seen in cycle N with FLUSH_CYCLES=F and no BadAR write:
  - flush in N+1..N+F
  - EPC write in N+F+1
  - CAUSE write in N+F+2
  - SR write in N+F+3
  - redirect in N+F+4
  - A BadAR write adds one cycle; skip_epc removes one cycle.
- ERET latency: SR write in N+1, redirect in N+2.
- pc_target holds its last value when pc_redirect=0.

Test Plan:
- Reset, then exc_valid=4'b0100, code[EX]=12, pc[EX]=0x00400010, sr_in=0x10, F=2:
  - flush=0111 in cycles 1-2
  - writes EPC=0x00400010, then CAUSE=0x30, then SR=0x02
  - redirect to 0x80000180 in cycle 6
  - stall high in cycles 1-6
- exc_valid=4'b1010, MEM code=4, MEM pc=0x00400020, badaddr=0x00000003:
  - MEM is selected and flush=1111
  - writes EPC, then CAUSE=0x10, then BadAR=0x3, then SR
  - redirect occurs one cycle later than in the previous test
- sr_in=0x02 (EXL set) with a SYSCALL (code 8) in ID:
  - no write to register 14
  - CAUSE=0x20 is written right after flush
  - redirect occurs one cycle earlier than in the first test
- eret with sr_in=0x02, epc_in=0x00400044:
  - SR write of 0x10 in cycle 1
  - redirect to 0x00400044 in cycle 2 with flush=1111
- eret and exc_valid[2] in the same cycle: exception entry sequence runs and no ERET redirect is produced.
- reset asserted during W_CAUSE:
  - next cycle: IDLE, cop_we=0, stall=0, pc_redirect=0
  - a new exception afterwards runs the full sequence normally.

Source files
------------

// File: rtl/exc_sequencer.sv
// exc_sequencer: picks the oldest pipeline exception (or an ERET), flushes and
// stalls the pipeline, performs the CP0 writes one at a time, then redirects fetch.
// Ports: exc_valid/exc_code/exc_pc/exc_badaddr/eret requests in; sr_in/epc_in CP0 state in;
//        cop_we/cop_wreg/cop_wdata CP0 write port out; flush/stall/pc_redirect/pc_target out.
module exc_sequencer #(
  parameter logic [31:0] KERNEL_VEC   = 32'h80000180,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   exc_valid,
  input  logic [19:0]  exc_code,
  input  logic [127:0] exc_pc,
  input  logic [31:0]  exc_badaddr,
  input  logic         eret,
  input  logic [31:0]  sr_in,
  input  logic [31:0]  epc_in,
  output logic         cop_we,
  output logic [4:0]   cop_wreg,
  output logic [31:0]  cop_wdata,
  output logic [3:0]   flush,
  output logic         stall,
  output logic         pc_redirect,
  output logic [31:0]  pc_target
);

  typedef enum logic [3:0] {
    S_IDLE, S_FLUSH, S_W_EPC, S_W_CAUSE, S_W_BADAR, S_W_SR, S_REDIRECT, S_ERET_SR, S_ERET_RD
  } state_t;

  localparam logic [4:0] REG_BADAR  = 5'd8;
  localparam logic [4:0] REG_SR     = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic [4:0]  code_q;
  logic [31:0] pc_q;
  logic [31:0] badaddr_q;
  logic [1:0]  sel_q;
  logic        skip_q;

  // Highest set index wins: MEM holds the oldest instruction.
  logic [1:0]  sel;
  logic [4:0]  sel_code;
  logic [31:0] sel_pc;
  always_comb begin
    sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (exc_valid[i]) sel = 2'(i);
    end
    sel_code = exc_code[5*sel +: 5];
    sel_pc   = exc_pc[32*sel +: 32];
  end

  // Entry sets EXL and drops to kernel mode; ERET does the reverse.
  logic [31:0] sr_entry, sr_eret, cause_data;
  logic        addr_err;
  assign sr_entry   = (sr_in | 32'h0000_0002) & ~32'h0000_0010;
  assign sr_eret    = (sr_in & ~32'h0000_0002) | 32'h0000_0010;
  assign cause_data = {25'b0, code_q, 2'b00};
  assign addr_err   = (code_q == 5'd4) || (code_q == 5'd5);

  // Younger-or-equal stages are squashed: everything at or before the faulting stage.
  function automatic logic [3:0] flush_mask(input logic [1:0] s);
    case (s)
      2'd0:    flush_mask = 4'b0001;
      2'd1:    flush_mask = 4'b0011;
      2'd2:    flush_mask = 4'b0111;
      default: flush_mask = 4'b1111;
    endcase
  endfunction

  // Outputs are registered: each transition loads the outputs of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      code_q      <= 5'd0;
      pc_q        <= 32'd0;
      badaddr_q   <= 32'd0;
      sel_q       <= 2'd0;
      skip_q      <= 1'b0;
      cop_we      <= 1'b0;
      cop_wreg    <= 5'd0;
      cop_wdata   <= 32'd0;
      flush       <= 4'd0;
      stall       <= 1'b0;
      pc_redirect <= 1'b0;
      pc_target   <= 32'd0;
    end else begin
      cop_we      <= 1'b0;
      pc_redirect <= 1'b0;
      flush       <= 4'd0;
      stall       <= 1'b1;
      case (state)
        S_IDLE: begin
          if (|exc_valid) begin
            code_q    <= sel_code;
            pc_q      <= sel_pc;
            badaddr_q <= exc_badaddr;
            sel_q     <= sel;
            skip_q    <= sr_in[1];
            cnt       <= FLUSH_INIT;
            flush     <= flush_mask(sel);
            state     <= S_FLUSH;
          end else if (eret) begin
            cop_we    <= 1'b1;
            cop_wreg  <= REG_SR;
            cop_wdata <= sr_eret;
            state     <= S_ERET_SR;
          end else begin
            stall     <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (cnt <= 4'd1) begin
            cop_we <= 1'b1;
            if (skip_q) begin
              // Nested exception: EPC keeps the original return address.
              cop_wreg  <= REG_CAUSE;
              cop_wdata <= cause_data;
              state     <= S_W_CAUSE;
            end else begin
              cop_wreg  <= REG_EPC;
              cop_wdata <= pc_q;
              state     <= S_W_EPC;
            end
          end else begin
            cnt   <= cnt - 4'd1;
            flush <= flush_mask(sel_q);
          end
        end
        S_W_EPC: begin
          cop_we    <= 1'b1;
          cop_wreg  <= REG_CAUSE;
          cop_wdata <= cause_data;
          state     <= S_W_CAUSE;
        end
        S_W_CAUSE: begin
          cop_we <= 1'b1;
          if (addr_err) begin
            cop_wreg  <= REG_BADAR;
            cop_wdata <= badaddr_q;
            state     <= S_W_BADAR;
          end else begin
            cop_wreg  <= REG_SR;
            cop_wdata <= sr_entry;
            state     <= S_W_SR;
          end
        end
        S_W_BADAR: begin
          cop_we    <= 1'b1;
          cop_wreg  <= REG_SR;
          cop_wdata <= sr_entry;
          state     <= S_W_SR;
        end
        S_W_SR: begin
          pc_redirect <= 1'b1;
          pc_target   <= KERNEL_VEC;
          flush       <= 4'b1111;
          state       <= S_REDIRECT;
        end
        S_ERET_SR: begin
          pc_redirect <= 1'b1;
          pc_target   <= epc_in;
          flush       <= 4'b1111;
          state       <= S_ERET_RD;
        end
        default: begin
          // S_REDIRECT, S_ERET_RD and any unused encoding return to idle.
          stall <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_sequencer.sv
module tb_exc_sequencer;

  localparam logic [31:0] KVEC = 32'h80000180;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   exc_valid;
  logic [19:0]  exc_code;
  logic [127:0] exc_pc;
  logic [31:0]  exc_badaddr;
  logic         eret;
  logic [31:0]  sr_in;
  logic [31:0]  epc_in;
  logic         cop_we;
  logic [4:0]   cop_wreg;
  logic [31:0]  cop_wdata;
  logic [3:0]   flush;
  logic         stall;
  logic         pc_redirect;
  logic [31:0]  pc_target;

  exc_sequencer #(.KERNEL_VEC(KVEC), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_badaddr(exc_badaddr), .eret(eret), .sr_in(sr_in),
    .epc_in(epc_in), .cop_we(cop_we), .cop_wreg(cop_wreg), .cop_wdata(cop_wdata),
    .flush(flush), .stall(stall), .pc_redirect(pc_redirect), .pc_target(pc_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [3:0]  fl;
    bit          st;
    bit          rd;
    logic [31:0] tgt;
    bit          full;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void push(bit we, logic [4:0] wreg, logic [31:0] wdata, logic [3:0] fl,
                               bit st, bit rd, logic [31:0] tgt, bit full);
    exp_t e;
    e.we = we; e.wreg = wreg; e.wdata = wdata; e.fl = fl;
    e.st = st; e.rd = rd; e.tgt = tgt; e.full = full;
    sb.push_back(e);
  endfunction

  function automatic void push_flush(logic [3:0] fl, int n);
    for (int i = 0; i < n; i++) push(0, 5'd0, 32'd0, fl, 1, 0, 32'd0, 0);
  endfunction
  function automatic void push_wr(logic [4:0] r, logic [31:0] d);
    push(1, r, d, 4'b0000, 1, 0, 32'd0, 0);
  endfunction
  function automatic void push_redir(logic [31:0] t);
    push(0, 5'd0, 32'd0, 4'b1111, 1, 1, t, 0);
  endfunction
  function automatic void push_idle();
    push(0, 5'd0, 32'd0, 4'b0000, 0, 0, 32'd0, 0);
  endfunction

  // Advance one cycle, sample away from the edge, compare against the oldest expectation.
  task automatic check_cycle(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_sb_empty: observed 0 entries expected >0", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_stall"}, 32'(stall), 32'(e.st));
      chk({tag, "_flush"}, 32'(flush), 32'(e.fl));
      chk({tag, "_cop_we"}, 32'(cop_we), 32'(e.we));
      chk({tag, "_redirect"}, 32'(pc_redirect), 32'(e.rd));
      if (e.we || e.full) begin
        chk({tag, "_wreg"}, 32'(cop_wreg), 32'(e.wreg));
        chk({tag, "_wdata"}, cop_wdata, e.wdata);
      end
      if (e.rd || e.full) chk({tag, "_target"}, pc_target, e.tgt);
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) check_cycle(tag);
  endtask

  task automatic drain(input string tag);
    while (sb.size() > 0) check_cycle(tag);
  endtask

  task automatic set_req(input int stage, input logic [4:0] code, input logic [31:0] pc);
    exc_valid[stage]          = 1'b1;
    exc_code[5*stage +: 5]    = code;
    exc_pc[32*stage +: 32]    = pc;
  endtask

  task automatic clear_req();
    exc_valid   = 4'b0;
    exc_code    = 20'd0;
    exc_pc      = 128'd0;
    exc_badaddr = 32'd0;
    eret        = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    sr_in  = 32'h10;
    epc_in = 32'd0;
    clear_req();

    // Reset state: everything zero, idle.
    push(0, 5'd0, 32'd0, 4'b0000, 0, 0, 32'd0, 1);
    push(0, 5'd0, 32'd0, 4'b0000, 0, 0, 32'd0, 1);
    drain("reset");
    reset = 1'b0;
    push_idle();
    drain("idle0");

    // EX exception, SYSCALL-free path: flush 0111 x2, EPC, CAUSE, SR, redirect.
    set_req(2, 5'd12, 32'h00400010);
    sr_in = 32'h10;
    push_flush(4'b0111, 2);
    push_wr(5'd14, 32'h00400010);
    push_wr(5'd13, 32'h30);
    push_wr(5'd12, 32'h02);
    push_redir(KVEC);
    push_idle();
    check_cycle("ex");
    clear_req();
    drain("ex");

    // MEM (AdEL) and ID together: MEM wins, BadAR write adds a cycle.
    set_req(1, 5'd10, 32'h00400004);
    set_req(3, 5'd4, 32'h00400020);
    exc_badaddr = 32'h00000003;
    push_flush(4'b1111, 2);
    push_wr(5'd14, 32'h00400020);
    push_wr(5'd13, 32'h10);
    push_wr(5'd8, 32'h00000003);
    push_wr(5'd12, 32'h02);
    push_redir(KVEC);
    push_idle();
    check_cycle("mem");
    clear_req();
    drain("mem");

    // EXL already set: no EPC write, CAUSE directly after flush. A request
    // arriving mid-sequence is ignored.
    sr_in = 32'h02;
    set_req(1, 5'd8, 32'h00400030);
    push_flush(4'b0011, 2);
    push_wr(5'd13, 32'h20);
    push_wr(5'd12, 32'h02);
    push_redir(KVEC);
    push_idle();
    push_idle();
    check_cycle("nested");
    clear_req();
    set_req(0, 5'd6, 32'h00400099);
    eret = 1'b1;
    check_cycle("nested");
    clear_req();
    drain("nested");

    // ERET: SR write then redirect to EPC.
    sr_in  = 32'h02;
    epc_in = 32'h00400044;
    eret   = 1'b1;
    push_wr(5'd12, 32'h10);
    push_redir(32'h00400044);
    push_idle();
    check_cycle("eret");
    clear_req();
    drain("eret");

    // ERET and an EX exception together: the exception wins.
    sr_in = 32'h10;
    eret  = 1'b1;
    set_req(2, 5'd12, 32'h00400050);
    push_flush(4'b0111, 2);
    push_wr(5'd14, 32'h00400050);
    push_wr(5'd13, 32'h30);
    push_wr(5'd12, 32'h02);
    push_redir(KVEC);
    push_idle();
    check_cycle("exc_eret");
    clear_req();
    drain("exc_eret");

    // Reset while the CAUSE write is on the port aborts the sequence.
    set_req(2, 5'd12, 32'h00400060);
    push_flush(4'b0111, 2);
    push_wr(5'd14, 32'h00400060);
    push_wr(5'd13, 32'h30);
    check_cycle("abort");
    clear_req();
    drain("abort");
    reset = 1'b1;
    push(0, 5'd0, 32'd0, 4'b0000, 0, 0, 32'd0, 1);
    drain("abort_rst");
    reset = 1'b0;
    push_idle();
    push_idle();
    drain("abort_idle");

    // Fresh exception after the abort runs the full sequence (AdES in MEM).
    set_req(3, 5'd5, 32'h00400100);
    exc_badaddr = 32'h00001001;
    push_flush(4'b1111, 2);
    push_wr(5'd14, 32'h00400100);
    push_wr(5'd13, 32'h14);
    push_wr(5'd8, 32'h00001001);
    push_wr(5'd12, 32'h02);
    push_redir(KVEC);
    push_idle();
    check_cycle("after_abort");
    clear_req();
    drain("after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
